// File: rtl/branch_resolve_if.sv
// Execute-stage branch resolution bus.
// Groups the EX-stage resolution inputs and the redirect, predictor-update and
// statistics outputs of branch_resolve.
//   master : the EX pipe side; drives the resolution inputs and observes the outputs
//   slave  : branch_resolve itself
// Resolution inputs : EX_Valid, EX_Stall, ExtFlush, IsBranch, IsJump, Taken,
//                     ActualTarget[31:0], InstrAddr[31:0], PPCCB[33:0]
// Outputs           : FlushPipeandPC, JmpAddr[31:0], WriteEnable, CB_o[1:0],
//                     JmpInstrAddr[31:0], UpdTarget[31:0], BranchCount[31:0],
//                     MispredCount[31:0]
interface branch_resolve_if;
   logic        EX_Valid;
   logic        EX_Stall;
   logic        ExtFlush;
   logic        IsBranch;
   logic        IsJump;
   logic        Taken;
   logic [31:0] ActualTarget;
   logic [31:0] InstrAddr;
   logic [33:0] PPCCB;
   logic        FlushPipeandPC;
   logic [31:0] JmpAddr;
   logic        WriteEnable;
   logic [1:0]  CB_o;
   logic [31:0] JmpInstrAddr;
   logic [31:0] UpdTarget;
   logic [31:0] BranchCount;
   logic [31:0] MispredCount;

   modport master (
      output EX_Valid, EX_Stall, ExtFlush, IsBranch, IsJump, Taken,
             ActualTarget, InstrAddr, PPCCB,
      input  FlushPipeandPC, JmpAddr, WriteEnable, CB_o, JmpInstrAddr,
             UpdTarget, BranchCount, MispredCount
   );

   modport slave (
      input  EX_Valid, EX_Stall, ExtFlush, IsBranch, IsJump, Taken,
             ActualTarget, InstrAddr, PPCCB,
      output FlushPipeandPC, JmpAddr, WriteEnable, CB_o, JmpInstrAddr,
             UpdTarget, BranchCount, MispredCount
   );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: back-end of the fetch prediction loop.
// Compares the prediction carried from fetch (PPCCB = {predicted next PC, 2-bit
// counter}) with the resolved outcome in EX. A mispredict issues a one-cycle
// FlushPipeandPC with the redirect address in JmpAddr; every resolved
// conditional branch returns the updated saturating counter on WriteEnable.
// After a flush, SHADOW unstalled cycles of wrong-path EX inputs are squashed.
// Ports:
//   Clk : rising-edge clock
//   Rst : synchronous, active-high reset
//   br  : branch_resolve_if.slave (resolution inputs, redirect/update outputs,
//         BranchCount / MispredCount statistics)
module branch_resolve #(
   parameter int unsigned SHADOW = 1
) (
   input  logic           Clk,
   input  logic           Rst,
   branch_resolve_if.slave br
);

   localparam logic [1:0] SHADOW_LD = 2'(SHADOW);

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  shadow_q, shadow_d;

   function automatic logic [1:0] sat_inc(input logic [1:0] cb);
      return (cb == 2'b11) ? cb : cb + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] cb);
      return (cb == 2'b00) ? cb : cb - 2'd1;
   endfunction

   // ---- stage p0: resolve the instruction presented in EX ----
   logic        vld_p0;
   logic        is_jmp_p0, is_br_p0;
   logic        act_taken_p0, pred_taken_p0, mispred_p0;
   logic [31:0] pred_pc_p0, seq_pc_p0, redirect_p0;
   logic [1:0]  cb_new_p0;

   always_comb begin
      vld_p0        = br.EX_Valid & ~br.EX_Stall & ~br.ExtFlush & (state_q == RUN);
      // A branch that is also flagged as a jump resolves as a jump.
      is_jmp_p0     = br.IsJump;
      is_br_p0      = br.IsBranch & ~br.IsJump;
      pred_pc_p0    = br.PPCCB[33:2];
      seq_pc_p0     = br.InstrAddr + 32'd4;
      act_taken_p0  = br.IsJump | (br.IsBranch & br.Taken);
      // Jumps carry no counter meaning: fetch predicted "taken" iff it did not
      // fall through to the sequential PC.
      pred_taken_p0 = is_jmp_p0 ? (pred_pc_p0 != seq_pc_p0) : br.PPCCB[1];
      mispred_p0    = (is_br_p0 | is_jmp_p0) &
                      ((pred_taken_p0 != act_taken_p0) |
                       (act_taken_p0 & (pred_pc_p0 != br.ActualTarget)));
      redirect_p0   = act_taken_p0 ? br.ActualTarget : seq_pc_p0;
      cb_new_p0     = act_taken_p0 ? sat_inc(br.PPCCB[1:0]) : sat_dec(br.PPCCB[1:0]);
   end

   // Squash-shadow FSM: only unstalled cycles consume the shadow.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      if (br.ExtFlush) begin
         state_d  = RUN;
         shadow_d = 2'd0;
      end else begin
         case (state_q)
            RUN: begin
               if (vld_p0 && mispred_p0) begin
                  state_d  = SQUASH;
                  shadow_d = SHADOW_LD;
               end
            end
            SQUASH: begin
               if (!br.EX_Stall) begin
                  shadow_d = shadow_q - 2'd1;
                  if (shadow_q <= 2'd1) begin
                     state_d  = RUN;
                     shadow_d = 2'd0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= RUN;
         shadow_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
      end
   end

   // ---- stage p1: registered pulses, held data fields, statistics ----
   logic        flush_p1, we_p1;
   logic [31:0] jmp_addr_p1, jmp_instr_addr_p1, upd_target_p1;
   logic [1:0]  cb_p1;
   logic [31:0] branch_cnt_p1, mispred_cnt_p1;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         flush_p1          <= 1'b0;
         we_p1             <= 1'b0;
         jmp_addr_p1       <= 32'd0;
         cb_p1             <= 2'b00;
         jmp_instr_addr_p1 <= 32'd0;
         upd_target_p1     <= 32'd0;
         branch_cnt_p1     <= 32'd0;
         mispred_cnt_p1    <= 32'd0;
      end else begin
         flush_p1 <= vld_p0 & mispred_p0;
         we_p1    <= vld_p0 & is_br_p0;
         if (vld_p0 && mispred_p0) begin
            jmp_addr_p1    <= redirect_p0;
            mispred_cnt_p1 <= mispred_cnt_p1 + 32'd1;
         end
         if (vld_p0 && is_br_p0) begin
            cb_p1             <= cb_new_p0;
            jmp_instr_addr_p1 <= br.InstrAddr;
            upd_target_p1     <= br.ActualTarget;
            branch_cnt_p1     <= branch_cnt_p1 + 32'd1;
         end
      end
   end

   assign br.FlushPipeandPC = flush_p1;
   assign br.JmpAddr        = jmp_addr_p1;
   assign br.WriteEnable    = we_p1;
   assign br.CB_o           = cb_p1;
   assign br.JmpInstrAddr   = jmp_instr_addr_p1;
   assign br.UpdTarget      = upd_target_p1;
   assign br.BranchCount    = branch_cnt_p1;
   assign br.MispredCount   = mispred_cnt_p1;

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve. Two instances (SHADOW=1 and SHADOW=2) see the
// same stimulus; a behavioural model predicts every cycle's outputs into a
// per-instance queue and a negedge monitor pops and compares them.
module tb_branch_resolve;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        s_valid = 1'b0, s_stall = 1'b0, s_eflush = 1'b0;
   logic        s_br = 1'b0, s_jmp = 1'b0, s_tk = 1'b0;
   logic [31:0] s_at = 32'd0, s_ia = 32'd0, s_ppc = 32'd0;
   logic [1:0]  s_cb = 2'b00;

   branch_resolve_if if0 ();
   branch_resolve_if if1 ();

   assign if0.EX_Valid = s_valid;          assign if1.EX_Valid = s_valid;
   assign if0.EX_Stall = s_stall;          assign if1.EX_Stall = s_stall;
   assign if0.ExtFlush = s_eflush;         assign if1.ExtFlush = s_eflush;
   assign if0.IsBranch = s_br;             assign if1.IsBranch = s_br;
   assign if0.IsJump   = s_jmp;            assign if1.IsJump   = s_jmp;
   assign if0.Taken    = s_tk;             assign if1.Taken    = s_tk;
   assign if0.ActualTarget = s_at;         assign if1.ActualTarget = s_at;
   assign if0.InstrAddr    = s_ia;         assign if1.InstrAddr    = s_ia;
   assign if0.PPCCB = {s_ppc, s_cb};       assign if1.PPCCB = {s_ppc, s_cb};

   branch_resolve #(.SHADOW(1)) dut0 (.Clk(clk), .Rst(rst), .br(if0));
   branch_resolve #(.SHADOW(2)) dut1 (.Clk(clk), .Rst(rst), .br(if1));

   typedef struct {
      logic        flush;
      logic [31:0] jmp_addr;
      logic        we;
      logic [1:0]  cb;
      logic [31:0] jia;
      logic [31:0] upd;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t m_out [2];
   int   m_squash_left [2];
   int   shadow_len [2] = '{1, 2};
   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;
   bit   mon_en = 1'b0;

   // Reference model: one step per rising edge, from the rules of operation.
   task automatic model_step(input int k);
      exp_t        o;
      logic [31:0] seq;
      bit          act_taken, pred_taken, wrong;
      int          c;
      o       = m_out[k];
      o.flush = 1'b0;
      o.we    = 1'b0;
      seq     = s_ia + 32'd4;
      if (rst) begin
         o = '{default: 0};
         m_squash_left[k] = 0;
      end else if (s_eflush) begin
         m_squash_left[k] = 0;
      end else if (m_squash_left[k] > 0) begin
         if (!s_stall) m_squash_left[k] = m_squash_left[k] - 1;
      end else if (s_valid && !s_stall && (s_br || s_jmp)) begin
         act_taken  = s_jmp || s_tk;
         pred_taken = s_jmp ? (s_ppc != seq) : s_cb[1];
         wrong      = (pred_taken != act_taken) || (act_taken && (s_ppc != s_at));
         if (wrong) begin
            o.flush    = 1'b1;
            o.jmp_addr = act_taken ? s_at : seq;
            o.mc       = o.mc + 32'd1;
            m_squash_left[k] = shadow_len[k];
         end
         if (!s_jmp) begin
            c = int'(s_cb);
            c = act_taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
            o.we  = 1'b1;
            o.cb  = 2'(c);
            o.jia = s_ia;
            o.upd = s_at;
            o.bc  = o.bc + 32'd1;
         end
      end
      m_out[k] = o;
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
      q0.push_back(m_out[0]);
      q1.push_back(m_out[1]);
      mon_en <= 1'b1;
      cycle  <= cycle + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", nm, cycle, act, req);
      end
   endtask

   task automatic cmp_rec(input string tag, input exp_t e, input exp_t a);
      chk({tag, ".FlushPipeandPC"}, 32'(a.flush), 32'(e.flush));
      chk({tag, ".JmpAddr"},        a.jmp_addr,   e.jmp_addr);
      chk({tag, ".WriteEnable"},    32'(a.we),    32'(e.we));
      chk({tag, ".CB_o"},           32'(a.cb),    32'(e.cb));
      chk({tag, ".JmpInstrAddr"},   a.jia,        e.jia);
      chk({tag, ".UpdTarget"},      a.upd,        e.upd);
      chk({tag, ".BranchCount"},    a.bc,         e.bc);
      chk({tag, ".MispredCount"},   a.mc,         e.mc);
   endtask

   always @(negedge clk) begin
      exp_t a0, a1;
      if (mon_en) begin
         a0 = '{if0.FlushPipeandPC, if0.JmpAddr, if0.WriteEnable, if0.CB_o,
                if0.JmpInstrAddr, if0.UpdTarget, if0.BranchCount, if0.MispredCount};
         a1 = '{if1.FlushPipeandPC, if1.JmpAddr, if1.WriteEnable, if1.CB_o,
                if1.JmpInstrAddr, if1.UpdTarget, if1.BranchCount, if1.MispredCount};
         if (q0.size() == 0) chk("sb0_nonempty", 32'd0, 32'd1);
         else cmp_rec("s1", q0.pop_front(), a0);
         if (q1.size() == 0) chk("sb1_nonempty", 32'd0, 32'd1);
         else cmp_rec("s2", q1.pop_front(), a1);
      end
   end

   // One stimulus cycle: inputs change just after the falling edge.
   task automatic cyc(input logic r, input logic v, input logic st, input logic ef,
                      input logic b, input logic j, input logic t,
                      input logic [31:0] at, input logic [31:0] ia,
                      input logic [31:0] ppc, input logic [1:0] cb);
      @(negedge clk);
      #1;
      rst = r; s_valid = v; s_stall = st; s_eflush = ef;
      s_br = b; s_jmp = j; s_tk = t; s_at = at; s_ia = ia; s_ppc = ppc; s_cb = cb;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00);
   endtask

   task automatic branch(input logic [31:0] ia, input logic [31:0] ppc, input logic [1:0] cb,
                         input logic t, input logic [31:0] at);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, t, at, ia, ppc, cb);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cycle);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ia, at, ppc;
      int          r;
      // Reset held for a few cycles.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h100, 32'h300, 2'b10);
      idle(1);
      // Correct taken prediction.
      branch(32'h100, 32'h200, 2'b10, 1'b1, 32'h200);
      // Not-taken mispredict, then taken branches into the shadow.
      branch(32'h100, 32'h200, 2'b11, 1'b0, 32'h200);
      branch(32'h140, 32'h180, 2'b10, 1'b1, 32'h180);
      branch(32'h144, 32'h188, 2'b10, 1'b1, 32'h188);
      branch(32'h148, 32'h190, 2'b10, 1'b1, 32'h190);
      idle(2);
      // Wrong target on taken prediction.
      branch(32'h100, 32'h300, 2'b10, 1'b1, 32'h400);
      idle(3);
      // Saturation at strong not-taken.
      branch(32'h100, 32'h104, 2'b00, 1'b0, 32'h500);
      // Sequential address wrap.
      branch(32'hFFFF_FFFC, 32'h10, 2'b10, 1'b0, 32'h10);
      idle(3);
      // BranchCount wrap.
      idle(1);
      @(negedge clk);
      #1;
      force dut0.branch_cnt_p1 = 32'hFFFF_FFFF;
      force dut1.branch_cnt_p1 = 32'hFFFF_FFFF;
      m_out[0].bc = 32'hFFFF_FFFF;
      m_out[1].bc = 32'hFFFF_FFFF;
      #1;
      release dut0.branch_cnt_p1;
      release dut1.branch_cnt_p1;
      branch(32'h100, 32'h200, 2'b11, 1'b1, 32'h200);
      idle(1);
      // Stall during the shadow.
      branch(32'h100, 32'h200, 2'b11, 1'b0, 32'h200);
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 32'h500, 32'h700, 2'b11);
      for (int i = 0; i < 4; i++)
         branch(32'h500 + 32'(i * 8), 32'h600, 2'b10, 1'b1, 32'h600);
      // Stalled valid mispredicting input in RUN.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h500, 32'h600, 2'b11);
      idle(1);
      // ExtFlush together with a mispredict, then a normal branch.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h500, 32'h600, 2'b11);
      branch(32'h500, 32'h600, 2'b10, 1'b1, 32'h600);
      // ExtFlush cancels an active shadow.
      branch(32'h100, 32'h200, 2'b11, 1'b0, 32'h200);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00);
      branch(32'h500, 32'h600, 2'b01, 1'b1, 32'h600);
      // Rst during the shadow, then a branch accepted normally.
      branch(32'h100, 32'h200, 2'b11, 1'b0, 32'h200);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h100, 32'h200, 2'b10);
      branch(32'h100, 32'h200, 2'b10, 1'b1, 32'h200);
      // Jumps: correct, fall-through predicted, wrong target, flagged as branch too.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 32'h700, 32'h800, 2'b00);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 32'h700, 32'h704, 2'b11);
      idle(3);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h900, 32'h700, 32'h800, 2'b01);
      idle(3);
      // Back-to-back correct branches and a non-control instruction.
      for (int i = 0; i < 4; i++)
         branch(32'hA00 + 32'(i * 4), 32'hA00 + 32'(i * 4) + 32'd4, 2'b01, 1'b0, 32'hB00);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB00, 32'hA00, 32'hC00, 2'b11);
      idle(2);

      // Randomized traffic.
      for (int n = 0; n < 2500; n++) begin
         ia = 32'($urandom_range(0, 63)) << 2;
         if ($urandom_range(0, 19) == 0) ia = 32'hFFFF_FFFC;
         at = 32'($urandom_range(0, 63)) << 2;
         r  = $urandom_range(0, 2);
         ppc = (r == 0) ? ia + 32'd4 : (r == 1) ? at : (32'($urandom_range(0, 63)) << 2);
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 1) == 1),
             at, ia, ppc, 2'($urandom_range(0, 3)));
      end
      idle(3);
      @(negedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
